// File: rtl/led_shift_driver.sv
// led_shift_driver
// Serialises the CPU LED byte into an external 74HC595-style shift/latch
// register. A transfer is launched when the byte changes, when a resend is
// forced, or once after every reset. Each transfer shifts eight bits with
// sclk and then pulses rclk once to latch the byte.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high reset
//   data_in      LED byte from the CPU output register
//   force_update single-cycle request to resend the current byte
//   sclk         serial shift clock
//   sdata        serial data, changes only while sclk is low
//   rclk         latch strobe, one pulse per completed byte
//   busy         high while a transfer is in progress
//   xfer_count   number of completed transfers (wraps)
module led_shift_driver #(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        force_update,
  output logic        sclk,
  output logic        sdata,
  output logic        rclk,
  output logic        busy,
  output logic [15:0] xfer_count
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] DivMax = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StLatchHi,
    StLatchLo
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      shadow_q, shadow_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            pending_q, pending_d;
  logic            sclk_q, sclk_d;
  logic            sdata_q, sdata_d;
  logic            rclk_q, rclk_d;
  logic            busy_q, busy_d;
  logic [15:0]     xfer_q, xfer_d;

  logic       tick;
  logic [7:0] shift_next;

  assign tick = (div_cnt_q == DivMax);

  // The bit to be sent next always sits at the outgoing end of the register.
  assign shift_next = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    pending_d = pending_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    rclk_d    = rclk_q;
    busy_d    = busy_q;
    xfer_d    = xfer_q;

    if (state_q == StIdle) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      // Requests while busy collapse into a single resend.
      if (force_update) begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        sclk_d = 1'b0;
        rclk_d = 1'b0;
        busy_d = 1'b0;
        if (pending_q || (data_in != shadow_q) || force_update) begin
          shift_d   = data_in;
          shadow_d  = data_in;
          bit_cnt_d = '0;
          pending_d = 1'b0;
          sdata_d   = MSB_FIRST ? data_in[7] : data_in[0];
          busy_d    = 1'b1;
          state_d   = StShiftLo;
        end
      end
      StShiftLo: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            rclk_d  = 1'b1;
            state_d = StLatchHi;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_next;
            sdata_d   = MSB_FIRST ? shift_next[7] : shift_next[0];
            state_d   = StShiftLo;
          end
        end
      end
      StLatchHi: begin
        if (tick) begin
          rclk_d  = 1'b0;
          state_d = StLatchLo;
        end
      end
      StLatchLo: begin
        if (tick) begin
          busy_d  = 1'b0;
          xfer_d  = xfer_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      shift_q   <= 8'h00;
      shadow_q  <= 8'h00;
      bit_cnt_q <= 3'd0;
      pending_q <= 1'b1;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      rclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      xfer_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      rclk_q    <= rclk_d;
      busy_q    <= busy_d;
      xfer_q    <= xfer_d;
    end
  end

  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign rclk       = rclk_q;
  assign busy       = busy_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Testbench for led_shift_driver: two instances (CLK_DIV=4 MSB first,
// CLK_DIV=1 LSB first). Stimulus pushes expected bytes into per-instance
// queues; a negedge monitor reassembles each shifted byte at the rclk pulse
// and checks it, along with busy/rclk widths and xfer_count.
module tb_led_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [7:0]  din [2];
  logic [1:0]  frc;
  logic [1:0]  sclk_v, sdata_v, rclk_v, busy_v;
  logic [15:0] xc [2];

  led_shift_driver #(.CLK_DIV(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(rst[0]), .data_in(din[0]), .force_update(frc[0]),
    .sclk(sclk_v[0]), .sdata(sdata_v[0]), .rclk(rclk_v[0]), .busy(busy_v[0]),
    .xfer_count(xc[0])
  );

  led_shift_driver #(.CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(rst[1]), .data_in(din[1]), .force_update(frc[1]),
    .sclk(sclk_v[1]), .sdata(sdata_v[1]), .rclk(rclk_v[1]), .busy(busy_v[1]),
    .xfer_count(xc[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues of expected bytes, one per instance.
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Monitor state.
  int         cyc = 0;
  logic [1:0] p_sclk = '0, p_sdata = '0, p_rclk = '0, p_busy = '0;
  int         rises [2] = '{0, 0};
  int         busy_len [2] = '{0, 0};
  int         rclk_len [2] = '{0, 0};
  int         last_rise [2] = '{0, 0};
  int         mon_xfers [2] = '{0, 0};
  logic [7:0] cap [2] = '{8'h00, 8'h00};

  task automatic mon_step(input int d);
    int         div;
    logic [7:0] e;
    div = (d == 0) ? 4 : 1;
    if (rst[d]) begin
      rises[d] = 0; cap[d] = 8'h00; busy_len[d] = 0; rclk_len[d] = 0; mon_xfers[d] = 0;
    end else begin
      if (busy_v[d]) busy_len[d]++;
      if (rclk_v[d]) rclk_len[d]++;
      if (sclk_v[d] && !p_sclk[d]) begin
        check("sdata_stable", int'(sdata_v[d]), int'(p_sdata[d]));
        if (rises[d] == 0) check("first_sclk_latency", busy_len[d], div + 1);
        rises[d]++;
        last_rise[d] = cyc;
        cap[d] = (d == 0) ? {cap[d][6:0], sdata_v[d]} : {sdata_v[d], cap[d][7:1]};
      end
      if (rclk_v[d] && !p_rclk[d]) begin
        check("sclk_rises", rises[d], 8);
        check("rclk_delay", cyc - last_rise[d], div);
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: dut %0d sent 'h%0h, expected none", d, cap[d]);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check(d == 0 ? "byte_a" : "byte_b", int'(cap[d]), int'(e));
        end
      end
      if (!rclk_v[d] && p_rclk[d]) begin
        check("rclk_width", rclk_len[d], div);
        rclk_len[d] = 0;
      end
      if (!busy_v[d] && p_busy[d]) begin
        check("busy_width", busy_len[d], 18 * div);
        mon_xfers[d]++;
        check("xfer_count", int'(xc[d]), mon_xfers[d]);
        busy_len[d] = 0;
        rises[d]    = 0;
        cap[d]      = 8'h00;
      end
    end
    p_sclk[d]  = sclk_v[d];
    p_sdata[d] = sdata_v[d];
    p_rclk[d]  = rclk_v[d];
    p_busy[d]  = busy_v[d];
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  task automatic wait_xfers(input int d, input int n, input int budget);
    int k = 0;
    while (mon_xfers[d] < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("xfers_reached", mon_xfers[d], n);
  endtask

  task automatic wait_busy(input int d, input int budget);
    int k = 0;
    while (!busy_v[d] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("busy_seen", int'(busy_v[d]), 1);
  endtask

  task automatic wait_rises(input int d, input int n, input int budget);
    int k = 0;
    while (rises[d] < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rises_reached", rises[d], n);
  endtask

  task automatic check_zero(input int d);
    check("rst_sclk",  int'(sclk_v[d]),  0);
    check("rst_sdata", int'(sdata_v[d]), 0);
    check("rst_rclk",  int'(rclk_v[d]),  0);
    check("rst_busy",  int'(busy_v[d]),  0);
    check("rst_count", int'(xc[d]),      0);
  endtask

  initial begin
    rst    = 2'b11;
    din[0] = 8'h00;
    din[1] = 8'h01;
    frc    = 2'b00;
    q0.push_back(8'h00);
    q1.push_back(8'h01);
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst = 2'b00;
    @(negedge clk);
    check("launch_after_reset_a", int'(busy_v[0]), 1);
    check("launch_after_reset_b", int'(busy_v[1]), 1);
    wait_xfers(0, 1, 500);
    wait_xfers(1, 1, 500);

    // LSB-first, single-cycle divider: 8'h80 sends its 1 last.
    din[1] = 8'h80;
    q1.push_back(8'h80);
    wait_xfers(1, 2, 500);

    din[0] = 8'hA5;
    q0.push_back(8'hA5);
    wait_xfers(0, 2, 500);

    // Changes while busy: only the latest value follows.
    din[0] = 8'h11;
    q0.push_back(8'h11);
    wait_busy(0, 50);
    repeat (10) @(negedge clk);
    din[0] = 8'h22;
    repeat (10) @(negedge clk);
    din[0] = 8'h33;
    q0.push_back(8'h33);
    wait_xfers(0, 4, 1000);
    repeat (3) @(negedge clk);
    check("idle_hold_busy", int'(busy_v[0]), 0);
    check("idle_hold_count", mon_xfers[0], 4);

    // Force in idle resends the unchanged byte.
    frc[0] = 1'b1;
    q0.push_back(8'h33);
    @(negedge clk);
    frc[0] = 1'b0;
    check("force_launch", int'(busy_v[0]), 1);
    // Three requests during busy collapse into one resend.
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(negedge clk);
      frc[0] = 1'b1;
      @(negedge clk);
      frc[0] = 1'b0;
    end
    q0.push_back(8'h33);
    wait_xfers(0, 6, 1000);
    repeat (100) @(negedge clk);
    check("no_extra_xfer", mon_xfers[0], 6);
    check("no_extra_busy", int'(busy_v[0]), 0);

    // Reset in the middle of bit 4 of 8'h5A.
    din[0] = 8'h5A;
    wait_rises(0, 5, 500);
    rst[0] = 1'b1;
    @(negedge clk);
    check_zero(0);
    @(negedge clk);
    rst[0] = 1'b0;
    q0.push_back(8'h5A);
    wait_xfers(0, 1, 500);

    repeat (20) @(negedge clk);
    check("queue_a_empty", q0.size(), 0);
    check("queue_b_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
